mef_multiciclo: RTL and testbench
=================================

// Module: mef_multiciclo
// PURPOSE
//  Parametrised multicycle RV32I control FSM. Drives datapath selects/enables from the opcode.
//  Adds a req/ack memory handshake with wait states, variable CPI (unused states skipped)
//  and a bus-timeout watchdog. Sits between IR opcode and datapath/memory port.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles mem_req may wait for mem_ack; 0 = watchdog disabled
//  SKIP_UNUSED  1   1: skip DIRECCION/ESCRIBE when unused (variable CPI); 0: fixed 5-state flow
// PORTS
//  clk            in   1  clock
//  reset          in   1  reset, synchronous, active-high
//  op             in   7  opcode inst[6:0]
//  mem_ack        in   1  memory done; read data valid / write committed this cycle
//  mem_req        out  1  memory access request, held until mem_ack
//  esc_pc,branch,sel_dir,esc_mem,esc_inst,esc_reg  out 1 each  datapath enables
//  sel_inmediato  out  3  000 I, 001 S, 010 B, 011 U, 100 J
//  modo_alu       out  2  00 add, 01 I-arith, 10 R, 11 branch compare
//  sel_op1        out  2  00 PC, 01 pc_inst, 10 rs1, 11 zero
//  sel_op2        out  2  00 rs2, 01 imm, 10 const 4
//  sel_y          out  2  00 dat_lectura, 01 ALU now, 10 ALU registered, 11 trap vector
//  instr_fin      out  1  one-cycle pulse on last cycle of each instruction
//  err_bus        out  1  sticky watchdog error
//  estado_dbg     out  3  current state code
// BEHAVIOUR
//  - Registered state; all outputs combinational from state/op/mem_ack; defaults all 0.
//  - reset: state=CARGA next cycle, watchdog cleared, err_bus=0; outputs then follow CARGA.
//  - CARGA: mem_req=1, sel_dir=0. Only when mem_ack=1: esc_inst=1, esc_pc=1, op1=00, op2=10,
//    modo=00, sel_y=01, then ->DECODIFICA. Else stay. Zero-wait ack (same cycle as req) legal.
//  - DECODIFICA: no enables. Legal op {3,19,23,35,51,55,99,103,111}: ->DIRECCION, or
//    ->MEMORIA_EJECUTA if SKIP_UNUSED && op in {19,23,51,55}. Illegal op: see CONFIGURATION.
//  - DIRECCION: 3,103: imm I, op1=10, op2=01; 35: imm S, op1=10, op2=01;
//    99: imm B, op1=01, op2=01; 111: imm J, op1=01, op2=01; modo=00. ->MEMORIA_EJECUTA.
//  - MEMORIA_EJECUTA: 3/35: mem_req=1, sel_dir=1, sel_y=10, esc_mem=(op==35); stay until mem_ack.
//    99: branch=1, sel_y=10, op1=10, op2=00, modo=11. 19: imm I, op1=10, op2=01, modo=01.
//    51: op1=10, op2=00, modo=10. 23: imm U, op1=01, op2=01. 55: imm U, op1=11, op2=01.
//    103/111: esc_pc=1, sel_y=10, op1=01, op2=10, modo=00.
//    Exit ->ESCRIBE; with SKIP_UNUSED, 35/99 ->CARGA (instr_fin=1) instead.
//  - ESCRIBE: esc_reg=1 for rd-writers; sel_y=00 for 3, else 10. 35/99 (SKIP_UNUSED=0): idle.
//    instr_fin=1. ->CARGA.
//  - CPI with SKIP_UNUSED=1, zero-wait: R/I/U 4, load 5, store/branch 4, jal/jalr 5.
//  - Watchdog: counts cycles with mem_req=1 && mem_ack=0; clears on ack or state change.
//    Reaching MEM_TIMEOUT: ->ERROR, err_bus=1. ERROR: all enables 0, mem_req=0; exit only by reset.
//  - mem_ack outside a requesting state is ignored. reset mid-wait: mem_req=0 the next cycle.
// CONFIGURATION
//  MEF_TRAP_EN defined: illegal op in DECODIFICA ->TRAP: esc_pc=1, sel_y=11, instr_fin=1, ->CARGA.
//  Not defined: illegal op is a NOP: DECODIFICA ->CARGA with instr_fin=1; no TRAP state.
// STRUCTURE
//  mef_pkg: opcode constants, state encoding (CARGA, DECODIFICA, DIRECCION, MEMORIA_EJECUTA,
//   ESCRIBE, TRAP, ERROR), sel_inmediato/modo_alu/sel_op*/sel_y encodings.
//  Sub-module mef_watchdog: timeout counter, width $clog2(MEM_TIMEOUT+1), clr/en in, expire out.
// TESTING
//  - add (op=51), ack tied 1, SKIP_UNUSED=1 -> 4 cycles; esc_reg=1, sel_y=10 in ESCRIBE; instr_fin once.
//  - lw (op=3), ack delayed 3 cycles in MEMORIA_EJECUTA -> mem_req,sel_dir held 4 cycles; esc_reg next.
//  - sw (op=35), SKIP_UNUSED=0 -> esc_mem=1 only in MEMORIA_EJECUTA; ESCRIBE idle; CPI 5.
//  - MEM_TIMEOUT=4, ack never in CARGA -> ERROR after 4 wait cycles, err_bus=1 until reset.
//  - op=7'h7F with MEF_TRAP_EN -> TRAP: esc_pc=1, sel_y=11; without: ->CARGA, no enables.
//  - reset asserted in MEMORIA_EJECUTA while waiting -> mem_req=0 next cycle, state CARGA.

Source files
------------

// File: rtl/mef_pkg.sv
// Shared encodings for the multicycle RV32I control FSM: opcodes, states, datapath selects.
// MEF_TRAP_EN adds the TRAP state used for illegal opcodes.
package mef_pkg;

  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_IMM    = 7'd19;
  localparam logic [6:0] OP_AUIPC  = 7'd23;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_REG    = 7'd51;
  localparam logic [6:0] OP_LUI    = 7'd55;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_JALR   = 7'd103;
  localparam logic [6:0] OP_JAL    = 7'd111;

  typedef enum logic [2:0] {
    S_CARGA           = 3'd0,
    S_DECODIFICA      = 3'd1,
    S_DIRECCION       = 3'd2,
    S_MEMORIA_EJECUTA = 3'd3,
    S_ESCRIBE         = 3'd4,
`ifdef MEF_TRAP_EN
    S_TRAP            = 3'd5,
`endif
    S_ERROR           = 3'd6
  } mef_state_t;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_IARITH = 2'b01;
  localparam logic [1:0] ALU_R      = 2'b10;
  localparam logic [1:0] ALU_BRANCH = 2'b11;

  localparam logic [1:0] OP1_PC     = 2'b00;
  localparam logic [1:0] OP1_PCINST = 2'b01;
  localparam logic [1:0] OP1_RS1    = 2'b10;
  localparam logic [1:0] OP1_ZERO   = 2'b11;

  localparam logic [1:0] OP2_RS2    = 2'b00;
  localparam logic [1:0] OP2_IMM    = 2'b01;
  localparam logic [1:0] OP2_CUATRO = 2'b10;

  localparam logic [1:0] Y_MEM     = 2'b00;
  localparam logic [1:0] Y_ALU     = 2'b01;
  localparam logic [1:0] Y_ALU_REG = 2'b10;
  localparam logic [1:0] Y_TRAP    = 2'b11;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_IMM, OP_AUIPC, OP_STORE, OP_REG,
      OP_LUI, OP_BRANCH, OP_JALR, OP_JAL: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic writes_rd(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_IMM, OP_AUIPC, OP_REG,
      OP_LUI, OP_JALR, OP_JAL: return 1'b1;
      default:                 return 1'b0;
    endcase
  endfunction

  // Opcodes with no address phase: they may jump straight to execute.
  function automatic logic skips_dir(input logic [6:0] op);
    case (op)
      OP_IMM, OP_AUIPC, OP_REG, OP_LUI: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mef_watchdog.sv
// Bus watchdog: counts consecutive unanswered request cycles, flags expiry at MEM_TIMEOUT.
// MEM_TIMEOUT = 0 disables expiry.
module mef_watchdog #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned CW    = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam int unsigned LIMIT = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (clr)
      r_cnt <= '0;
    else if (en && (r_cnt != CW'(LIMIT)))
      r_cnt <= r_cnt + CW'(1);
  end

  // Fires on the MEM_TIMEOUT-th waiting cycle so the FSM leaves on that edge.
  assign expire = (MEM_TIMEOUT != 0) && en && (r_cnt == CW'(LIMIT));

endmodule

// File: rtl/mef_multiciclo.sv
// Multicycle RV32I control FSM with req/ack memory handshake, variable CPI and bus watchdog.
// MEF_TRAP_EN: illegal opcodes go to TRAP; otherwise they retire as a NOP.
module mef_multiciclo
  import mef_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned SKIP_UNUSED = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       esc_pc,
  output logic       branch,
  output logic       sel_dir,
  output logic       esc_mem,
  output logic       esc_inst,
  output logic       esc_reg,
  output logic [2:0] sel_inmediato,
  output logic [1:0] modo_alu,
  output logic [1:0] sel_op1,
  output logic [1:0] sel_op2,
  output logic [1:0] sel_y,
  output logic       instr_fin,
  output logic       err_bus,
  output logic [2:0] estado_dbg
);

  localparam logic SKIP = (SKIP_UNUSED != 0);

  mef_state_t r_state;
  mef_state_t w_next;
  logic       r_err_bus;
  logic       w_expire;
  logic       w_wd_clr;
  logic       w_wd_en;
  logic       w_mem_op;
  logic       w_early_fin;

  assign w_mem_op    = (op == OP_LOAD) || (op == OP_STORE);
  assign w_early_fin = SKIP && ((op == OP_STORE) || (op == OP_BRANCH));

  assign w_wd_en  = mem_req && !mem_ack;
  assign w_wd_clr = reset || mem_ack || (w_next != r_state);

  mef_watchdog #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_watchdog (
    .clk   (clk),
    .clr   (w_wd_clr),
    .en    (w_wd_en),
    .expire(w_expire)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_CARGA: begin
        if (w_expire)     w_next = S_ERROR;
        else if (mem_ack) w_next = S_DECODIFICA;
      end
      S_DECODIFICA: begin
        if (is_legal(op))
          w_next = (SKIP && skips_dir(op)) ? S_MEMORIA_EJECUTA : S_DIRECCION;
        else
`ifdef MEF_TRAP_EN
          w_next = S_TRAP;
`else
          w_next = S_CARGA;
`endif
      end
      S_DIRECCION: w_next = S_MEMORIA_EJECUTA;
      S_MEMORIA_EJECUTA: begin
        if (!w_mem_op)    w_next = w_early_fin ? S_CARGA : S_ESCRIBE;
        else if (w_expire) w_next = S_ERROR;
        else if (mem_ack) w_next = w_early_fin ? S_CARGA : S_ESCRIBE;
      end
      S_ESCRIBE: w_next = S_CARGA;
`ifdef MEF_TRAP_EN
      S_TRAP:    w_next = S_CARGA;
`endif
      S_ERROR:   w_next = S_ERROR;
      default:   w_next = S_CARGA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_CARGA;
      r_err_bus <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_expire) r_err_bus <= 1'b1;
    end
  end

  // Outputs are held low while reset is asserted so an in-flight request drops immediately.
  always_comb begin
    mem_req       = 1'b0;
    esc_pc        = 1'b0;
    branch        = 1'b0;
    sel_dir       = 1'b0;
    esc_mem       = 1'b0;
    esc_inst      = 1'b0;
    esc_reg       = 1'b0;
    sel_inmediato = IMM_I;
    modo_alu      = ALU_ADD;
    sel_op1       = OP1_PC;
    sel_op2       = OP2_RS2;
    sel_y         = Y_MEM;
    instr_fin     = 1'b0;
    if (!reset) begin
      case (r_state)
        S_CARGA: begin
          mem_req = 1'b1;
          if (mem_ack) begin
            esc_inst = 1'b1;
            esc_pc   = 1'b1;
            sel_op2  = OP2_CUATRO;
            sel_y    = Y_ALU;
          end
        end
        S_DECODIFICA: begin
`ifndef MEF_TRAP_EN
          if (!is_legal(op)) instr_fin = 1'b1;
`endif
        end
        S_DIRECCION: begin
          case (op)
            OP_LOAD, OP_JALR: begin sel_op1 = OP1_RS1; sel_op2 = OP2_IMM; end
            OP_STORE: begin
              sel_inmediato = IMM_S; sel_op1 = OP1_RS1; sel_op2 = OP2_IMM;
            end
            OP_BRANCH: begin
              sel_inmediato = IMM_B; sel_op1 = OP1_PCINST; sel_op2 = OP2_IMM;
            end
            OP_JAL: begin
              sel_inmediato = IMM_J; sel_op1 = OP1_PCINST; sel_op2 = OP2_IMM;
            end
            default: ;
          endcase
        end
        S_MEMORIA_EJECUTA: begin
          case (op)
            OP_LOAD, OP_STORE: begin
              mem_req   = 1'b1;
              sel_dir   = 1'b1;
              sel_y     = Y_ALU_REG;
              esc_mem   = (op == OP_STORE);
              instr_fin = w_early_fin && mem_ack;
            end
            OP_BRANCH: begin
              branch    = 1'b1;
              sel_y     = Y_ALU_REG;
              sel_op1   = OP1_RS1;
              sel_op2   = OP2_RS2;
              modo_alu  = ALU_BRANCH;
              instr_fin = w_early_fin;
            end
            OP_IMM: begin
              sel_inmediato = IMM_I; sel_op1 = OP1_RS1; sel_op2 = OP2_IMM;
              modo_alu = ALU_IARITH;
            end
            OP_REG: begin sel_op1 = OP1_RS1; sel_op2 = OP2_RS2; modo_alu = ALU_R; end
            OP_AUIPC: begin
              sel_inmediato = IMM_U; sel_op1 = OP1_PCINST; sel_op2 = OP2_IMM;
            end
            OP_LUI: begin
              sel_inmediato = IMM_U; sel_op1 = OP1_ZERO; sel_op2 = OP2_IMM;
            end
            OP_JALR, OP_JAL: begin
              esc_pc  = 1'b1;
              sel_y   = Y_ALU_REG;
              sel_op1 = OP1_PCINST;
              sel_op2 = OP2_CUATRO;
            end
            default: ;
          endcase
        end
        S_ESCRIBE: begin
          instr_fin = 1'b1;
          if (writes_rd(op)) begin
            esc_reg = 1'b1;
            sel_y   = (op == OP_LOAD) ? Y_MEM : Y_ALU_REG;
          end
        end
`ifdef MEF_TRAP_EN
        S_TRAP: begin
          esc_pc    = 1'b1;
          sel_y     = Y_TRAP;
          instr_fin = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign err_bus    = r_err_bus;
  assign estado_dbg = r_state;

endmodule

// File: tb/tb_mef_multiciclo.sv
// Directed bench for mef_multiciclo: variable-CPI instance with short watchdog, fixed-flow instance.
module tb_mef_multiciclo;

  typedef struct packed {
    logic [2:0] st;
    logic       req, pc, br, dir, wm, inst, rg;
    logic [2:0] imm;
    logic [1:0] modo, op1, op2, y;
    logic       fin, err;
  } vec_t;

  logic clk;
  int   n_checks;
  int   n_fail;

  logic       a_reset, a_ack, b_reset, b_ack;
  logic [6:0] a_op, b_op;
  logic       a_req, a_pc, a_br, a_dir, a_wm, a_inst, a_rg, a_fin, a_err;
  logic       b_req, b_pc, b_br, b_dir, b_wm, b_inst, b_rg, b_fin, b_err;
  logic [2:0] a_imm, a_st, b_imm, b_st;
  logic [1:0] a_modo, a_op1, a_op2, a_y, b_modo, b_op1, b_op2, b_y;
  vec_t       a_got, b_got;

  assign a_got = {a_st, a_req, a_pc, a_br, a_dir, a_wm, a_inst, a_rg,
                  a_imm, a_modo, a_op1, a_op2, a_y, a_fin, a_err};
  assign b_got = {b_st, b_req, b_pc, b_br, b_dir, b_wm, b_inst, b_rg,
                  b_imm, b_modo, b_op1, b_op2, b_y, b_fin, b_err};

  mef_multiciclo #(.MEM_TIMEOUT(4), .SKIP_UNUSED(1)) u_dut_a (
    .clk(clk), .reset(a_reset), .op(a_op), .mem_ack(a_ack),
    .mem_req(a_req), .esc_pc(a_pc), .branch(a_br), .sel_dir(a_dir),
    .esc_mem(a_wm), .esc_inst(a_inst), .esc_reg(a_rg),
    .sel_inmediato(a_imm), .modo_alu(a_modo), .sel_op1(a_op1), .sel_op2(a_op2),
    .sel_y(a_y), .instr_fin(a_fin), .err_bus(a_err), .estado_dbg(a_st)
  );

  mef_multiciclo #(.MEM_TIMEOUT(0), .SKIP_UNUSED(0)) u_dut_b (
    .clk(clk), .reset(b_reset), .op(b_op), .mem_ack(b_ack),
    .mem_req(b_req), .esc_pc(b_pc), .branch(b_br), .sel_dir(b_dir),
    .esc_mem(b_wm), .esc_inst(b_inst), .esc_reg(b_rg),
    .sel_inmediato(b_imm), .modo_alu(b_modo), .sel_op1(b_op1), .sel_op2(b_op2),
    .sel_y(b_y), .instr_fin(b_fin), .err_bus(b_err), .estado_dbg(b_st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input int st, input int req, input int pc, input int br,
                              input int dir, input int wm, input int inst, input int rg,
                              input int imm, input int modo, input int op1, input int op2,
                              input int y, input int fin, input int err);
    mk = {3'(st), 1'(req), 1'(pc), 1'(br), 1'(dir), 1'(wm), 1'(inst), 1'(rg),
          3'(imm), 2'(modo), 2'(op1), 2'(op2), 2'(y), 1'(fin), 1'(err)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ca(input string tag, input vec_t e);
    #1;
    check(tag, 32'(a_got), 32'(e));
  endtask

  task automatic cb(input string tag, input vec_t e);
    #1;
    check(tag, 32'(b_got), 32'(e));
  endtask

  vec_t V_ZERO, V_FETCH, V_DEC, V_CIDLE, V_LDW;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    V_ZERO  = mk(0, 0,0,0,0,0,0,0, 0,0,0,0,0, 0,0);
    V_FETCH = mk(0, 1,1,0,0,0,1,0, 0,0,0,'b10,'b01, 0,0);
    V_DEC   = mk(1, 0,0,0,0,0,0,0, 0,0,0,0,0, 0,0);
    V_CIDLE = mk(0, 1,0,0,0,0,0,0, 0,0,0,0,0, 0,0);
    V_LDW   = mk(3, 1,0,0,1,0,0,0, 0,0,0,0,'b10, 0,0);

    a_reset = 1'b1; a_ack = 1'b0; a_op = 7'd0;
    b_reset = 1'b1; b_ack = 1'b0; b_op = 7'd0;
    tick();
    ca("rst", V_ZERO);

    // add: CARGA, DECODIFICA, MEMORIA_EJECUTA, ESCRIBE
    a_reset = 1'b0; a_op = 7'd51; a_ack = 1'b1;
    ca("add_c", V_FETCH); tick();
    ca("add_d", V_DEC); tick();
    ca("add_m", mk(3, 0,0,0,0,0,0,0, 0,'b10,'b10,'b00,0, 0,0)); tick();
    ca("add_e", mk(4, 0,0,0,0,0,0,1, 0,0,0,0,'b10, 1,0)); tick();

    // lw with ack three cycles late
    a_op = 7'd3;
    ca("lw_c", V_FETCH); tick();
    a_ack = 1'b0;
    ca("lw_d", V_DEC); tick();
    ca("lw_dir", mk(2, 0,0,0,0,0,0,0, 0,0,'b10,'b01,0, 0,0)); tick();
    for (int i = 0; i < 3; i++) begin
      ca("lw_wait", V_LDW); tick();
    end
    a_ack = 1'b1;
    ca("lw_ack", V_LDW); tick();
    ca("lw_e", mk(4, 0,0,0,0,0,0,1, 0,0,0,0,'b00, 1,0)); tick();

    // sw, variable CPI: retires in MEMORIA_EJECUTA
    a_op = 7'd35;
    ca("sw_c", V_FETCH); tick();
    ca("sw_d", V_DEC); tick();
    ca("sw_dir", mk(2, 0,0,0,0,0,0,0, 'b001,0,'b10,'b01,0, 0,0)); tick();
    ca("sw_m", mk(3, 1,0,0,1,1,0,0, 0,0,0,0,'b10, 1,0)); tick();

    // beq
    a_op = 7'd99;
    ca("beq_c", V_FETCH); tick();
    ca("beq_d", V_DEC); tick();
    ca("beq_dir", mk(2, 0,0,0,0,0,0,0, 'b010,0,'b01,'b01,0, 0,0)); tick();
    ca("beq_m", mk(3, 0,0,1,0,0,0,0, 0,'b11,'b10,'b00,'b10, 1,0)); tick();

    // jal
    a_op = 7'd111;
    ca("jal_c", V_FETCH); tick();
    ca("jal_d", V_DEC); tick();
    ca("jal_dir", mk(2, 0,0,0,0,0,0,0, 'b100,0,'b01,'b01,0, 0,0)); tick();
    ca("jal_m", mk(3, 0,1,0,0,0,0,0, 0,0,'b01,'b10,'b10, 0,0)); tick();
    ca("jal_e", mk(4, 0,0,0,0,0,0,1, 0,0,0,0,'b10, 1,0)); tick();

    // illegal opcode
    a_op = 7'h7F;
    ca("ill_c", V_FETCH); tick();
`ifdef MEF_TRAP_EN
    ca("ill_d", V_DEC); tick();
    ca("ill_trap", mk(5, 0,1,0,0,0,0,0, 0,0,0,0,'b11, 1,0)); tick();
`else
    ca("ill_d", mk(1, 0,0,0,0,0,0,0, 0,0,0,0,0, 1,0)); tick();
`endif

    // reset while a load waits for its ack
    a_op = 7'd3;
    ca("rmw_c", V_FETCH); tick();
    a_ack = 1'b0;
    ca("rmw_d", V_DEC); tick();
    tick();
    ca("rmw_wait", V_LDW);
    a_reset = 1'b1; tick();
    ca("rmw_rst", V_ZERO);

    // fetch never acknowledged: ERROR after four waiting cycles
    a_reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ca("to_wait", V_CIDLE); tick();
    end
    ca("to_err", mk(6, 0,0,0,0,0,0,0, 0,0,0,0,0, 0,1));
    a_ack = 1'b1; tick();
    ca("to_stick1", mk(6, 0,0,0,0,0,0,0, 0,0,0,0,0, 0,1)); tick();
    ca("to_stick2", mk(6, 0,0,0,0,0,0,0, 0,0,0,0,0, 0,1));
    a_reset = 1'b1; tick();
    ca("to_rst", V_ZERO);
    a_reset = 1'b0;
    ca("to_refetch", V_FETCH);

    // fixed flow, watchdog disabled: long fetch stall is harmless
    b_reset = 1'b0; b_op = 7'd35;
    for (int i = 0; i < 20; i++) tick();
    cb("b_nowd", V_CIDLE);
    b_ack = 1'b1;
    cb("b_sw_c", V_FETCH); tick();
    cb("b_sw_d", V_DEC); tick();
    cb("b_sw_dir", mk(2, 0,0,0,0,0,0,0, 'b001,0,'b10,'b01,0, 0,0)); tick();
    cb("b_sw_m", mk(3, 1,0,0,1,1,0,0, 0,0,0,0,'b10, 0,0)); tick();
    cb("b_sw_e", mk(4, 0,0,0,0,0,0,0, 0,0,0,0,0, 1,0)); tick();

    b_op = 7'd51;
    cb("b_add_c", V_FETCH); tick();
    cb("b_add_d", V_DEC); tick();
    cb("b_add_dir", mk(2, 0,0,0,0,0,0,0, 0,0,0,0,0, 0,0)); tick();
    cb("b_add_m", mk(3, 0,0,0,0,0,0,0, 0,'b10,'b10,'b00,0, 0,0)); tick();
    cb("b_add_e", mk(4, 0,0,0,0,0,0,1, 0,0,0,0,'b10, 1,0)); tick();
    cb("b_add_next", V_FETCH);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
